interrupt_ctrl: RTL and testbench

//  Multi-channel interrupt controller replacing single-flag interrupt registers in the UART/peripheral path.

---
 rtl/interrupt_ctrl_pkg.sv | 24 ++
 rtl/interrupt_ctrl_if.sv | 44 ++++
 rtl/interrupt_ctrl_prio_enc.sv | 20 ++
 rtl/interrupt_ctrl.sv | 101 ++++++++++
 tb/tb_interrupt_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/interrupt_ctrl_pkg.sv
// Shared types for the multi-channel interrupt controller.
// Holds the FSM state encoding and a small popcount helper.
package interrupt_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    IC_IDLE,
    IC_REQ
  } ic_state_e;

  function automatic logic [5:0] popcount32(
    input logic [31:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/interrupt_ctrl_if.sv
// Bus between the interrupt controller and its consumer.
// The master drives sources and handshake inputs.
interface interrupt_ctrl_if #(
  parameter int N_CH = 4
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(N_CH + 1);

  logic [N_CH-1:0]  src;
  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  clear;
  logic             ack;
  logic             irq;
  logic [IDX_W-1:0] irq_id;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  ovf;
  logic [CNT_W-1:0] pend_cnt;

  modport master (
    output src,
    output en,
    output clear,
    output ack,
    input  irq,
    input  irq_id,
    input  pending,
    input  ovf,
    input  pend_cnt
  );

  modport slave (
    input  src,
    input  en,
    input  clear,
    input  ack,
    output irq,
    output irq_id,
    output pending,
    output ovf,
    output pend_cnt
  );

endinterface

// File: rtl/interrupt_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder.
// Purely combinational; reusable for any request vector width.
module intr_prio_enc #(
  parameter int N_CH  = 4,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Multi-channel interrupt controller: sticky pending/ovf flags,
// enable mask, lowest-index priority and a req/ack handshake.
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter int              N_CH      = 4,
  parameter logic [N_CH-1:0] EDGE_MASK = {N_CH{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  interrupt_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(N_CH + 1);

  ic_state_e        state_q;
  ic_state_e        state_d;
  logic [IDX_W-1:0] id_q;
  logic [IDX_W-1:0] id_d;
  logic [N_CH-1:0]  src_q;
  logic [N_CH-1:0]  pend_q;
  logic [N_CH-1:0]  pend_d;
  logic [N_CH-1:0]  ovf_q;
  logic [N_CH-1:0]  ovf_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N_CH-1:0]  set_ev;
  logic [N_CH-1:0]  ack_clr;
  logic [N_CH-1:0]  clr;
  logic             win_any;
  logic [IDX_W-1:0] win_idx;

  intr_prio_enc #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_enc (
    .req (pend_q & bus.en),
    .any (win_any),
    .idx (win_idx)
  );

  // Level channels ignore src_q, so they set every cycle src is high.
  assign set_ev = bus.src & ~(src_q & EDGE_MASK);

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      ack_clr[i] = (state_q == IC_REQ) && bus.ack
                   && (id_q == IDX_W'(i));
    end
  end

  assign clr    = ack_clr | bus.clear;
  assign pend_d = set_ev | (pend_q & ~clr);
  assign ovf_d  = (ovf_q & ~bus.clear)
                | (set_ev & pend_q & ~clr);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IC_IDLE: begin
        if (win_any) begin
          state_d = IC_REQ;
          id_d    = win_idx;
        end
      end
      IC_REQ: begin
        if (bus.ack || !pend_q[id_q] || !bus.en[id_q]) begin
          state_d = IC_IDLE;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IC_IDLE;
      id_q    <= '0;
      src_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      src_q   <= bus.src;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= CNT_W'(popcount32(32'(pend_q)));
    end
  end

  assign bus.irq      = (state_q == IC_REQ);
  assign bus.irq_id   = id_q;
  assign bus.pending  = pend_q;
  assign bus.ovf      = ovf_q;
  assign bus.pend_cnt = cnt_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: an edge-only instance and a mixed
// edge/level instance driven from cycle tables via a scoreboard.
module tb_interrupt_ctrl;

  typedef struct packed {
    logic       rst;
    logic [3:0] src;
    logic [3:0] en;
    logic [3:0] clr;
    logic       ack;
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  interrupt_ctrl_if #(.N_CH(4)) bus_a ();
  interrupt_ctrl_if #(.N_CH(4)) bus_b ();

  interrupt_ctrl #(
    .N_CH      (4),
    .EDGE_MASK (4'hF)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  interrupt_ctrl #(
    .N_CH      (4),
    .EDGE_MASK (4'b1110)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t tab_a[$];
  vec_t tab_b[$];
  logic [3:0] prev_pend[2];

  function automatic vec_t V(
    input logic rst, input logic [3:0] src,
    input logic [3:0] en, input logic [3:0] clr,
    input logic ack, input logic irq,
    input logic [1:0] id, input logic [3:0] pend,
    input logic [3:0] ovf
  );
    vec_t v;
    v.rst = rst; v.src = src; v.en = en;
    v.clr = clr; v.ack = ack; v.irq = irq;
    v.id = id; v.pend = pend; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int d, input vec_t v,
                     input string tag);
    vec_t       e;
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic [2:0] cnt;
    logic [3:0] omask;
    logic [2:0] ecnt;
    @(negedge clk);
    if (d == 0) begin
      rst_a = v.rst; bus_a.src = v.src; bus_a.en = v.en;
      bus_a.clear = v.clr; bus_a.ack = v.ack;
    end else begin
      rst_b = v.rst; bus_b.src = v.src; bus_b.en = v.en;
      bus_b.clear = v.clr; bus_b.ack = v.ack;
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (d == 0) begin
      irq = bus_a.irq; id = bus_a.irq_id; pend = bus_a.pending;
      ovf = bus_a.ovf; cnt = bus_a.pend_cnt; omask = 4'hF;
    end else begin
      irq = bus_b.irq; id = bus_b.irq_id; pend = bus_b.pending;
      ovf = bus_b.ovf; cnt = bus_b.pend_cnt; omask = 4'b1110;
    end
    ecnt = e.rst ? 3'd0 : 3'($countones(prev_pend[d]));
    chk({tag, ".irq"}, 32'(irq), 32'(e.irq));
    if (e.irq || e.rst) chk({tag, ".irq_id"}, 32'(id), 32'(e.id));
    chk({tag, ".pending"}, 32'(pend), 32'(e.pend));
    chk({tag, ".ovf"}, 32'(ovf & omask), 32'(e.ovf & omask));
    chk({tag, ".pend_cnt"}, 32'(cnt), 32'(ecnt));
    prev_pend[d] = e.pend;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.src = '0; bus_a.en = '0; bus_a.clear = '0; bus_a.ack = 1'b0;
    bus_b.src = '0; bus_b.en = '0; bus_b.clear = '0; bus_b.ack = 1'b0;
    prev_pend[0] = '0; prev_pend[1] = '0;

    // reset with sources high, then edge-through-reset and clear
    repeat (3) tab_a.push_back(V(1, 4'hF, 0, 0, 0, 0, 0, 4'h0, 0));
    tab_a.push_back(V(0, 4'hF, 0, 0,    0, 0, 0, 4'hF, 0));
    tab_a.push_back(V(0, 4'h0, 0, 4'hF, 0, 0, 0, 4'h0, 0));
    tab_a.push_back(V(0, 4'h0, 0, 0,    0, 0, 0, 4'h0, 0));
    // single edge on ch2
    tab_a.push_back(V(0, 4'h4, 4'hF, 0, 0, 0, 0, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 2, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 2, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 2, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 0));
    // ch3 held against later higher-priority ch1
    tab_a.push_back(V(0, 4'h8, 4'hF, 0, 0, 0, 0, 4'h8, 0));
    tab_a.push_back(V(0, 4'h2, 4'hF, 0, 0, 1, 3, 4'hA, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 3, 4'hA, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h2, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 1, 4'h2, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 0));
    // set and ack in the same cycle on ch0
    tab_a.push_back(V(0, 4'h1, 4'hF, 0, 0, 0, 0, 4'h1, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 0, 4'h1, 0));
    tab_a.push_back(V(0, 4'h1, 4'hF, 0, 1, 0, 0, 4'h1, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 0, 4'h1, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 0));
    // masked overflow, late enable, software-clear withdrawal
    tab_a.push_back(V(0, 4'h2, 4'h0, 0,    0, 0, 0, 4'h2, 4'h0));
    tab_a.push_back(V(0, 4'h0, 4'h0, 0,    0, 0, 0, 4'h2, 4'h0));
    tab_a.push_back(V(0, 4'h2, 4'h0, 0,    0, 0, 0, 4'h2, 4'h2));
    tab_a.push_back(V(0, 4'h0, 4'h0, 0,    0, 0, 0, 4'h2, 4'h2));
    tab_a.push_back(V(0, 4'h0, 4'h2, 0,    0, 1, 1, 4'h2, 4'h2));
    tab_a.push_back(V(0, 4'h0, 4'h2, 4'h2, 0, 1, 1, 4'h0, 4'h0));
    tab_a.push_back(V(0, 4'h0, 4'h2, 0,    0, 0, 0, 4'h0, 4'h0));
    tab_a.push_back(V(0, 4'h0, 4'h2, 0,    0, 0, 0, 4'h0, 4'h0));
    // withdrawal by disabling the requested channel
    tab_a.push_back(V(0, 4'h4, 4'hF, 0, 0, 0, 0, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 2, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 2, 4'h4, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 0));
    // ack while idle is ignored
    tab_a.push_back(V(0, 4'h1, 4'h0, 0,    0, 0, 0, 4'h1, 0));
    tab_a.push_back(V(0, 4'h0, 4'h0, 0,    1, 0, 0, 4'h1, 0));
    tab_a.push_back(V(0, 4'h0, 4'h0, 4'h1, 0, 0, 0, 4'h0, 0));
    // reset beats ack mid-handshake
    tab_a.push_back(V(0, 4'h8, 4'hF, 0, 0, 0, 0, 4'h8, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 3, 4'h8, 0));
    tab_a.push_back(V(1, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 0));
    tab_a.push_back(V(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 0));

    foreach (tab_a[i]) run(0, tab_a[i], $sformatf("a%0d", i));

    // level source on ch0: re-set on ack, sticky after drop, reset
    tab_b.push_back(V(1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 0));
    tab_b.push_back(V(0, 4'h1, 4'hF, 0, 0, 0, 0, 4'h1, 0));
    tab_b.push_back(V(0, 4'h1, 4'hF, 0, 0, 1, 0, 4'h1, 0));
    tab_b.push_back(V(0, 4'h1, 4'hF, 0, 1, 0, 0, 4'h1, 0));
    tab_b.push_back(V(0, 4'h1, 4'hF, 0, 0, 1, 0, 4'h1, 0));
    tab_b.push_back(V(1, 4'h1, 4'hF, 0, 0, 0, 0, 4'h0, 0));
    tab_b.push_back(V(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 0));
    tab_b.push_back(V(0, 4'h1, 4'hF, 0, 0, 0, 0, 4'h1, 0));
    tab_b.push_back(V(0, 4'h0, 4'hF, 0, 0, 1, 0, 4'h1, 0));
    tab_b.push_back(V(0, 4'h0, 4'hF, 0, 1, 0, 0, 4'h0, 0));
    tab_b.push_back(V(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 0));

    foreach (tab_b[i]) run(1, tab_b[i], $sformatf("b%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
